// File: rtl/demux_rr_sched_if.sv
// Signal bundle between the burst scheduler (master) and its environment:
// serial source, per-channel requests and the demux pins it drives.
interface demux_rr_sched_if;
    // src_valid/src_ready: a bit moves on a rising clk edge where both are high.
    // The source holds src_bit and src_valid until that edge. src_ready depends
    // only on scheduler state, never combinationally on src_valid.
    logic [3:0] req;
    logic       src_valid;
    logic       src_bit;
    logic       src_ready;
    logic [1:0] sel;
    logic       a;
    logic [3:0] ch_valid;
    logic [3:0] grant;
    logic       busy;

    modport master (
        input  req, src_valid, src_bit,
        output src_ready, sel, a, ch_valid, grant, busy
    );

    modport slave (
        output req, src_valid, src_bit,
        input  src_ready, sel, a, ch_valid, grant, busy
    );
endinterface

// File: rtl/demux_rr_sched.sv
// Round-robin burst scheduler: grants one of four consumers, holds sel for the
// whole grant and streams BURST_LEN serial bits onto the demux 'a' pin.
module demux_rr_sched #(
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    demux_rr_sched_if.master  bus,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_sel;
    logic [4:0] r_cnt;
    logic [3:0] r_gap_cnt;
    logic       r_a;
    logic [3:0] r_ch_valid;
    logic [3:0] r_grant;
    logic       r_busy;

    logic       w_found;
    logic [1:0] w_off;
    logic [1:0] w_idx;
    logic       w_ready;
    logic       w_hs;
    logic       w_last;

    // Circular search from r_ptr; descending loop so the smallest offset wins.
    always_comb begin
        w_found = 1'b0;
        w_off   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[r_ptr + 2'(k)]) begin
                w_found = 1'b1;
                w_off   = 2'(k);
            end
        end
    end

    assign w_idx   = r_ptr + w_off;
    assign w_ready = (r_state == ST_XFER);
    assign w_hs    = bus.src_valid && w_ready;
    assign w_last  = ((r_cnt + 5'd1) == 5'(BURST_LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 2'd0;
            r_sel      <= 2'd0;
            r_cnt      <= 5'd0;
            r_gap_cnt  <= 4'd0;
            r_a        <= 1'b0;
            r_ch_valid <= 4'd0;
            r_grant    <= 4'd0;
            r_busy     <= 1'b0;
        end else begin
            r_a        <= 1'b0;
            r_ch_valid <= 4'd0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= 4'b0001 << w_idx;
                        r_sel   <= w_idx;
                        r_busy  <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_cnt   <= 5'd0;
                    r_state <= ST_XFER;
                end
                ST_XFER: begin
                    if (w_hs) begin
                        r_a        <= bus.src_bit;
                        r_ch_valid <= r_grant;
                        r_cnt      <= r_cnt + 5'd1;
                        if (w_last) begin
                            r_gap_cnt <= 4'd0;
                            r_state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    // The burst's last strobe is visible during the first GAP cycle.
                    if (r_gap_cnt == 4'(GAP_CYCLES - 1)) begin
                        r_ptr   <= r_sel + 2'd1;
                        r_grant <= 4'd0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.src_ready = w_ready;
    assign bus.sel       = r_sel;
    assign bus.a         = r_a;
    assign bus.ch_valid  = r_ch_valid;
    assign bus.grant     = r_grant;
    assign bus.busy      = r_busy;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched: random/directed source traffic, a transaction-level
// arbitration model feeding an expected queue, and a strobe monitor.
module tb_demux_rr_sched;

    localparam int BL     = 4;
    localparam int GC     = 1;
    localparam int PERIOD = 2 + BL + GC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    demux_rr_sched_if bus();

    demux_rr_sched #(.BURST_LEN(BL), .GAP_CYCLES(GC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait expired (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
    endfunction

    function automatic int idx_of(input logic [3:0] oh);
        case (oh)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    logic [4:0] exp_q[$];
    int         m_ptr = 0;
    int         m_ch = 0;
    int         m_hs = 0;
    logic       hs_pending = 1'b0;

    // A handshake seen here happens at the next rising edge; the channel of a
    // burst is decided by the round-robin rule when its first bit moves.
    always @(negedge clk) begin
        logic [3:0] oh;
        if (!rst_n) begin
            exp_q.delete();
            m_ptr = 0;
            m_hs = 0;
            hs_pending = 1'b0;
        end else if (bus.src_valid && bus.src_ready) begin
            if (m_hs == 0 || m_hs == BL) begin
                m_ch = rr_pick(bus.req, m_ptr);
                m_ptr = (m_ch + 1) % 4;
                m_hs = 0;
            end
            m_hs++;
            oh = 4'b0001 << m_ch;
            exp_q.push_back({oh, bus.src_bit});
            hs_pending = 1'b1;
        end else begin
            hs_pending = 1'b0;
        end
    end

    // ---------------- source driver ----------------
    logic pat_q[$];
    logic rand_mode = 1'b0;
    logic reload = 1'b0;
    int   stall_cnt = 0;

    initial begin
        logic took;
        bus.src_valid = 1'b0;
        bus.src_bit = 1'b0;
        forever begin
            @(posedge clk);
            took = hs_pending;
            #1;
            if (stall_cnt > 0) begin
                bus.src_valid = 1'b0;
                stall_cnt--;
            end else if (!bus.src_valid || took || reload) begin
                if (rand_mode && !reload) bus.src_valid = ($urandom_range(0, 3) != 0);
                else bus.src_valid = 1'b1;
                if (pat_q.size() > 0) bus.src_bit = pat_q.pop_front();
                else bus.src_bit = 1'($urandom_range(0, 1));
                reload = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [3:0] grant_log[$];
    int         grant_cyc[$];
    int         busy_len_log[$];
    logic       a_log[$];
    logic [3:0] prev_grant = 4'd0;
    logic [1:0] prev_sel = 2'd0;
    logic       prev_busy = 1'b0;
    int         strobes = 0;
    int         busy_rise = 0;

    always @(negedge clk) begin
        logic [4:0] e;
        if (!rst_n) begin
            prev_grant = 4'd0;
            prev_sel = 2'd0;
            prev_busy = 1'b0;
            strobes = 0;
        end else begin
            if (bus.ch_valid != 4'd0) begin
                chk("chv_eq_grant", bus.ch_valid, bus.grant);
                if (exp_q.size() == 0) begin
                    chk("strobe_expected", bus.ch_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_ch", bus.ch_valid, e[4:1]);
                    chk("strobe_bit", bus.a, e[0]);
                end
                strobes++;
                a_log.push_back(bus.a);
            end else begin
                chk("a_idle_zero", bus.a, 0);
            end
            if (prev_grant == 4'd0 && bus.grant != 4'd0) begin
                grant_log.push_back(bus.grant);
                grant_cyc.push_back(cyc);
                chk("sel_index", bus.sel, idx_of(bus.grant));
            end else begin
                chk("sel_hold", bus.sel, prev_sel);
            end
            if (prev_grant != 4'd0 && bus.grant != prev_grant) begin
                chk("grant_release", bus.grant, 0);
                chk("strobes_per_grant", strobes, BL);
                strobes = 0;
            end
            if (bus.busy && !prev_busy) busy_rise = cyc;
            if (!bus.busy && prev_busy) busy_len_log.push_back(cyc - busy_rise);
            prev_grant = bus.grant;
            prev_sel = bus.sel;
            prev_busy = bus.busy;
        end
    end

    // ---------------- bounded waits ----------------
    task automatic wait_hs(input int n);
        int t = 0;
        while (m_hs != n) begin
            @(negedge clk);
            #1;
            t++;
            if (t > 500) begin
                fail_timeout("wait_handshake");
                return;
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bus.busy || bus.grant != 4'd0) begin
            @(negedge clk);
            #1;
            t++;
            if (t > 500) begin
                fail_timeout("wait_idle");
                return;
            end
        end
    endtask

    task automatic wait_grants(input int n);
        int t = 0;
        while (grant_log.size() < n) begin
            @(negedge clk);
            #1;
            t++;
            if (t > 500) begin
                fail_timeout("wait_grant");
                return;
            end
        end
    endtask

    // ---------------- directed + random sequence ----------------
    logic [3:0] fair_exp [5];
    logic       burst_bits [4];

    initial begin
        fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b0100;
        fair_exp[3] = 4'b1000; fair_exp[4] = 4'b0001;
        burst_bits[0] = 1'b1; burst_bits[1] = 1'b0; burst_bits[2] = 1'b1; burst_bits[3] = 1'b1;
        bus.req = 4'b1111;
        rst_n = 1'b0;

        // Reset values with all requests and src_valid high
        repeat (3) @(negedge clk);
        chk("rst_grant", bus.grant, 0);
        chk("rst_sel", bus.sel, 0);
        chk("rst_a", bus.a, 0);
        chk("rst_ch_valid", bus.ch_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_src_ready", bus.src_ready, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", bus.grant, 4'b0001);
        chk("post_rst_sel", bus.sel, 0);
        chk("post_rst_busy", bus.busy, 1);

        // Fairness with req held at 1111
        wait_grants(5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) chk("fair_grant", grant_log[i], fair_exp[i]);
        end
        for (int i = 1; i < 5; i++) begin
            if (i < grant_cyc.size()) chk("fair_period", grant_cyc[i] - grant_cyc[i-1], PERIOD);
        end
        wait_hs(1);
        bus.req = 4'b0000;
        wait_idle();

        // Single burst to channel 2 with a known bit pattern
        grant_log.delete();
        busy_len_log.delete();
        a_log.delete();
        for (int i = 0; i < 4; i++) pat_q.push_back(burst_bits[i]);
        reload = 1'b1;
        bus.req = 4'b0100;
        wait_grants(1);
        if (grant_log.size() > 0) chk("single_grant", grant_log[0], 4'b0100);
        chk("single_sel", bus.sel, 2);
        wait_hs(1);
        bus.req = 4'b0000;
        wait_idle();
        chk("single_nstrobe", a_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < a_log.size()) chk("single_bit", a_log[i], burst_bits[i]);
        end
        if (busy_len_log.size() > 0) chk("single_busy_len", busy_len_log[0], 1 + BL + GC);
        else fail_timeout("single_busy_len");

        // Source stall of 3 cycles after the 2nd handshake
        bus.req = 4'b0001;
        wait_hs(2);
        stall_cnt = 3;
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", bus.src_ready, 1);
            chk("stall_chv", bus.ch_valid, 0);
        end
        wait_hs(4);
        @(negedge clk);
        chk("gap_ready", bus.src_ready, 0);
        chk("gap_busy", bus.busy, 1);
        chk("gap_final_strobe", bus.ch_valid, 4'b0001);
        #1 bus.req = 4'b0000;
        wait_idle();

        // Request withdrawal after the first handshake
        grant_log.delete();
        a_log.delete();
        bus.req = 4'b0010;
        wait_hs(1);
        bus.req = 4'b0000;
        wait_idle();
        if (grant_log.size() > 0) chk("wd_grant", grant_log[0], 4'b0010);
        chk("wd_nstrobe", a_log.size(), 4);
        grant_log.delete();
        bus.req = 4'b0011;
        wait_grants(1);
        if (grant_log.size() > 0) chk("wd_next_grant", grant_log[0], 4'b0001);
        wait_hs(1);
        bus.req = 4'b0000;
        wait_idle();

        // Asynchronous reset in the middle of a burst
        bus.req = 4'b1001;
        wait_hs(2);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rmid_ch_valid", bus.ch_valid, 0);
        chk("rmid_a", bus.a, 0);
        chk("rmid_grant", bus.grant, 0);
        chk("rmid_src_ready", bus.src_ready, 0);
        chk("rmid_busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        grant_log.delete();
        #1 rst_n = 1'b1;
        wait_grants(1);
        if (grant_log.size() > 0) chk("rmid_regrant", grant_log[0], 4'b0001);
        wait_hs(1);
        bus.req = 4'b0000;
        wait_idle();

        // Random traffic: random requests, random source gaps, mid-burst req changes
        rand_mode = 1'b1;
        repeat (12) begin
            bus.req = 4'($urandom_range(1, 15));
            wait_hs(1);
            bus.req = 4'($urandom_range(0, 15));
            wait_hs(BL);
        end
        bus.req = 4'b0000;
        wait_idle();
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
